// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the PET memory front end.
// Controller state encoding plus the I/O page and chip-select bit positions.
package ram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] IO_PAGE  = 8'hE8;
    localparam int         PIA1_BIT = 4;
    localparam int         PIA2_BIT = 5;
    localparam int         VIA_BIT  = 6;

endpackage

// File: rtl/pet_addr_decode.sv
// PET CPU address decoder: splits the 6502 space into RAM and the $E8xx I/O page.
// Purely combinational; chip selects may overlap, matching the original machine.
module pet_addr_decode
    import ram_bus_pkg::*;
#(
    parameter int CPU_ADDR_WIDTH = 16
) (
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                      ram_en_o,
    output logic                      io_en_o,
    output logic                      pia1_en_o,
    output logic                      pia2_en_o,
    output logic                      via_en_o
);

    logic io_hit;

    assign io_hit    = (cpu_addr_i[CPU_ADDR_WIDTH-1 -: 8] == IO_PAGE);
    assign io_en_o   = io_hit;
    assign ram_en_o  = !io_hit;
    assign pia1_en_o = io_hit & cpu_addr_i[PIA1_BIT];
    assign pia2_en_o = io_hit & cpu_addr_i[PIA2_BIT];
    assign via_en_o  = io_hit & cpu_addr_i[VIA_BIT];

endmodule

// File: rtl/ram_bus_ctl.sv
// Wishbone B4 pipelined single-beat SRAM controller plus the CPU address decoder.
// Accept at edge N, ack in cycle N+3; stall is held high until the SRAM cycle drains.
module ram_bus_ctl
    import ram_bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int CPU_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cycle_i,
    input  logic                      wb_strobe_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                      ram_oe_o,
    output logic                      ram_we_o,
    input  logic [DATA_WIDTH-1:0]     ram_data_i,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic                      ram_data_oe,
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                      ram_en_o,
    output logic                      io_en_o,
    output logic                      pia1_en_o,
    output logic                      pia2_en_o,
    output logic                      via_en_o
);

    state_t                    state_q, state_d;
    logic                      ack_q, ack_d;
    logic                      oe_q, oe_d;
    logic                      we_q, we_d;
    logic                      doe_q, doe_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]     rdat_q, rdat_d;
    logic                      is_wr_q, is_wr_d;
    logic                      cyc_ok_q, cyc_ok_d;
    logic                      accept;

    pet_addr_decode #(
        .CPU_ADDR_WIDTH (CPU_ADDR_WIDTH)
    ) u_decode (
        .cpu_addr_i (cpu_addr_i),
        .ram_en_o   (ram_en_o),
        .io_en_o    (io_en_o),
        .pia1_en_o  (pia1_en_o),
        .pia2_en_o  (pia2_en_o),
        .via_en_o   (via_en_o)
    );

    assign wb_stall_o = (state_q != IDLE);
    assign accept     = wb_cycle_i & wb_strobe_i & !wb_stall_o;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        oe_d     = 1'b0;
        we_d     = 1'b0;
        doe_d    = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        is_wr_d  = is_wr_q;
        cyc_ok_d = cyc_ok_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ACCESS;
                    addr_d   = wb_addr_i;
                    wdat_d   = wb_data_i;
                    is_wr_d  = wb_we_i;
                    oe_d     = !wb_we_i;
                    we_d     = wb_we_i;
                    doe_d    = wb_we_i;
                    cyc_ok_d = 1'b1;
                end
            end
            ACCESS: begin
                // Write strobe drops here; data stays driven one more cycle for hold time.
                state_d  = HOLD;
                oe_d     = !is_wr_q;
                doe_d    = is_wr_q;
                cyc_ok_d = cyc_ok_q & wb_cycle_i;
            end
            HOLD: begin
                state_d = IDLE;
                ack_d   = cyc_ok_q & wb_cycle_i;
                if (!is_wr_q) begin
                    rdat_d = ram_data_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            doe_q    <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
            is_wr_q  <= 1'b0;
            cyc_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            doe_q    <= doe_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            is_wr_q  <= is_wr_d;
            cyc_ok_q <= cyc_ok_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_data_o   = rdat_q;
    assign ram_addr_o  = addr_q;
    assign ram_oe_o    = oe_q;
    assign ram_we_o    = we_q;
    assign ram_data_o  = wdat_q;
    assign ram_data_oe = doe_q;

endmodule

// File: tb/tb_ram_bus_ctl.sv
// Directed bench for ram_bus_ctl: decoder sweep, write/read timing, back-to-back,
// cycle abort and reset-in-HOLD, against a one-location SRAM stand-in.
module tb_ram_bus_ctl;

    logic        clk;
    logic        rst_n;
    logic [16:0] wb_addr;
    logic [7:0]  wb_wdat;
    logic [7:0]  wb_rdat;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_stall;
    logic        wb_ack;
    logic [16:0] ram_addr;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        ram_doe;
    logic [15:0] cpu_addr;
    logic        ram_en, io_en, pia1_en, pia2_en, via_en;

    logic [7:0]  sram_val;
    logic        ovr_en;
    int          errors;
    int          checks;

    ram_bus_ctl dut (
        .wb_clock_i  (clk),
        .wb_reset_i  (rst_n),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_wdat),
        .wb_data_o   (wb_rdat),
        .wb_we_i     (wb_we),
        .wb_cycle_i  (wb_cyc),
        .wb_strobe_i (wb_stb),
        .wb_stall_o  (wb_stall),
        .wb_ack_o    (wb_ack),
        .ram_addr_o  (ram_addr),
        .ram_oe_o    (ram_oe),
        .ram_we_o    (ram_we),
        .ram_data_i  (ram_din),
        .ram_data_o  (ram_dout),
        .ram_data_oe (ram_doe),
        .cpu_addr_i  (cpu_addr),
        .ram_en_o    (ram_en),
        .io_en_o     (io_en),
        .pia1_en_o   (pia1_en),
        .pia2_en_o   (pia2_en),
        .via_en_o    (via_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM stand-in: remembers the last byte written; override forces a fixed read value.
    always @(posedge clk) begin
        if (ram_we) sram_val <= ram_dout;
    end
    assign ram_din = ram_oe ? (ovr_en ? 8'h5A : sram_val) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [16:0] a, input logic [7:0] d, input logic we);
        wb_addr = a;
        wb_wdat = d;
        wb_we   = we;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
    endtask

    function automatic logic [31:0] dec_vec();
        return {27'd0, ram_en, io_en, pia1_en, pia2_en, via_en};
    endfunction

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        wb_addr  = '0;
        wb_wdat  = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        cpu_addr = '0;
        ovr_en   = 1'b0;
        sram_val = 8'h00;
        #3;
        chk("rst_ack",   {31'd0, wb_ack},   32'd0);
        chk("rst_oe",    {31'd0, ram_oe},   32'd0);
        chk("rst_we",    {31'd0, ram_we},   32'd0);
        chk("rst_doe",   {31'd0, ram_doe},  32'd0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_addr",  {15'd0, ram_addr}, 32'd0);
        chk("rst_rdat",  {24'd0, wb_rdat},  32'd0);
        chk("rst_wdat",  {24'd0, ram_dout}, 32'd0);

        // Decoder, bits {ram, io, pia1, pia2, via}
        cpu_addr = 16'hE810; #1; chk("dec_E810", dec_vec(), 32'b01100);
        cpu_addr = 16'hE820; #1; chk("dec_E820", dec_vec(), 32'b01010);
        cpu_addr = 16'hE840; #1; chk("dec_E840", dec_vec(), 32'b01001);
        cpu_addr = 16'hE800; #1; chk("dec_E800", dec_vec(), 32'b01000);
        cpu_addr = 16'hE900; #1; chk("dec_E900", dec_vec(), 32'b10000);
        cpu_addr = 16'h8000; #1; chk("dec_8000", dec_vec(), 32'b10000);
        cpu_addr = 16'hE870; #1; chk("dec_E870", dec_vec(), 32'b01111);

        tick();
        rst_n = 1'b1;
        tick();

        // Single write
        req(17'h1_2345, 8'hA5, 1'b1);
        tick();
        wb_stb = 1'b0;
        chk("wr1_we",    {31'd0, ram_we},   32'd1);
        chk("wr1_oe",    {31'd0, ram_oe},   32'd0);
        chk("wr1_doe",   {31'd0, ram_doe},  32'd1);
        chk("wr1_addr",  {15'd0, ram_addr}, 32'h1_2345);
        chk("wr1_data",  {24'd0, ram_dout}, 32'hA5);
        chk("wr1_stall", {31'd0, wb_stall}, 32'd1);
        chk("wr1_ack",   {31'd0, wb_ack},   32'd0);
        tick();
        chk("wr2_we",    {31'd0, ram_we},   32'd0);
        chk("wr2_doe",   {31'd0, ram_doe},  32'd1);
        chk("wr2_addr",  {15'd0, ram_addr}, 32'h1_2345);
        chk("wr2_data",  {24'd0, ram_dout}, 32'hA5);
        chk("wr2_ack",   {31'd0, wb_ack},   32'd0);
        tick();
        chk("wr3_ack",   {31'd0, wb_ack},   32'd1);
        chk("wr3_doe",   {31'd0, ram_doe},  32'd0);
        chk("wr3_stall", {31'd0, wb_stall}, 32'd0);
        chk("wr3_rdat",  {24'd0, wb_rdat},  32'd0);
        wb_cyc = 1'b0;
        tick();
        chk("wr4_ack",   {31'd0, wb_ack},   32'd0);
        chk("wr4_addr",  {15'd0, ram_addr}, 32'h1_2345);

        // Single read with forced SRAM value
        ovr_en = 1'b1;
        req(17'h0_4321, 8'h00, 1'b0);
        tick();
        wb_stb = 1'b0;
        chk("rd1_oe",    {31'd0, ram_oe},   32'd1);
        chk("rd1_we",    {31'd0, ram_we},   32'd0);
        chk("rd1_doe",   {31'd0, ram_doe},  32'd0);
        chk("rd1_stall", {31'd0, wb_stall}, 32'd1);
        chk("rd1_addr",  {15'd0, ram_addr}, 32'h0_4321);
        tick();
        chk("rd2_oe",    {31'd0, ram_oe},   32'd1);
        chk("rd2_stall", {31'd0, wb_stall}, 32'd1);
        chk("rd2_ack",   {31'd0, wb_ack},   32'd0);
        tick();
        chk("rd3_ack",   {31'd0, wb_ack},   32'd1);
        chk("rd3_rdat",  {24'd0, wb_rdat},  32'h5A);
        chk("rd3_oe",    {31'd0, ram_oe},   32'd0);
        wb_cyc = 1'b0;
        ovr_en = 1'b0;
        tick();

        // Back-to-back write then read, strobe held high
        req(17'h0_0100, 8'h3C, 1'b1);
        tick();
        chk("bb1_stall", {31'd0, wb_stall}, 32'd1);
        wb_we   = 1'b0;
        wb_wdat = 8'h00;
        tick();
        tick();
        chk("bb3_ack",   {31'd0, wb_ack},   32'd1);
        chk("bb3_stall", {31'd0, wb_stall}, 32'd0);
        tick();
        wb_stb = 1'b0;
        chk("bb4_ack",   {31'd0, wb_ack},   32'd0);
        chk("bb4_stall", {31'd0, wb_stall}, 32'd1);
        chk("bb4_oe",    {31'd0, ram_oe},   32'd1);
        tick();
        chk("bb5_ack",   {31'd0, wb_ack},   32'd0);
        tick();
        chk("bb6_ack",   {31'd0, wb_ack},   32'd1);
        chk("bb6_rdat",  {24'd0, wb_rdat},  32'h3C);
        wb_cyc = 1'b0;
        tick();
        chk("bb7_ack",   {31'd0, wb_ack},   32'd0);

        // Cycle dropped during ACCESS
        req(17'h1_FFFF, 8'h77, 1'b1);
        tick();
        chk("ab1_we",    {31'd0, ram_we},   32'd1);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        tick();
        chk("ab2_we",    {31'd0, ram_we},   32'd0);
        chk("ab2_doe",   {31'd0, ram_doe},  32'd1);
        tick();
        chk("ab3_ack",   {31'd0, wb_ack},   32'd0);
        chk("ab3_stall", {31'd0, wb_stall}, 32'd0);
        chk("ab3_sram",  {24'd0, sram_val}, 32'h77);
        chk("ab3_rdat",  {24'd0, wb_rdat},  32'h3C);
        chk("ab3_addr",  {15'd0, ram_addr}, 32'h1_FFFF);
        tick();
        chk("ab4_ack",   {31'd0, wb_ack},   32'd0);

        // Reset asserted while in HOLD
        req(17'h0_0200, 8'h00, 1'b0);
        tick();
        wb_stb = 1'b0;
        tick();
        chk("rh_oe_pre", {31'd0, ram_oe},   32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rh_oe",     {31'd0, ram_oe},   32'd0);
        chk("rh_ack",    {31'd0, wb_ack},   32'd0);
        chk("rh_stall",  {31'd0, wb_stall}, 32'd0);
        chk("rh_addr",   {15'd0, ram_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        wb_cyc = 1'b0;
        tick();
        chk("rh2_ack",   {31'd0, wb_ack},   32'd0);
        chk("rh2_stall", {31'd0, wb_stall}, 32'd0);
        chk("rh2_oe",    {31'd0, ram_oe},   32'd0);
        tick();
        chk("rh3_ack",   {31'd0, wb_ack},   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
